// File: rtl/lock_code_sender_if.sv
// Digit handshake and lock status between the code sender and the lock.
interface lock_code_sender_if;
    logic [3:0] in_seq;
    logic       seq_valid;
    logic       seq_ready;
    logic [3:0] unlock;

    modport master (
        output in_seq,
        output seq_valid,
        input  seq_ready,
        input  unlock
    );

    modport slave (
        input  in_seq,
        input  seq_valid,
        output seq_ready,
        output unlock
    );
endinterface

// File: rtl/lock_code_sender.sv
// Sends a latched four-digit code to a lock, waits for its verdict
// and locks out after too many consecutive failures.
module lock_code_sender #(
    parameter int RESP_TIMEOUT = 8,
    parameter int MAX_FAILS    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        code,
    input  logic               clear_lockout,
    lock_code_sender_if.master lk,
    output logic               busy,
    output logic               done,
    output logic               granted,
    output logic [1:0]         fail_cnt,
    output logic               locked_out
);
    localparam logic [7:0] TO = 8'(RESP_TIMEOUT);
    localparam logic [1:0] MF = 2'(MAX_FAILS);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        LOCKOUT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] code_q, code_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  timer_q, timer_d;
    logic [1:0]  fail_q, fail_d;
    logic        granted_q, granted_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        lock_q, lock_d;
    logic        valid_q, valid_d;
    logic [3:0]  seq_q, seq_d;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        fail_d    = fail_q;
        granted_d = granted_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    code_d    = code;
                    idx_d     = 2'd0;
                    timer_d   = 8'd0;
                    granted_d = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (valid_q && lk.seq_ready) begin
                    if (idx_q == 2'd3) begin
                        timer_d = 8'd0;
                        state_d = WAIT_RESP;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            WAIT_RESP: begin
                // A grant seen on the last allowed cycle still counts.
                if (lk.unlock == 4'b1111) begin
                    granted_d = 1'b1;
                    fail_d    = 2'd0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else if (timer_q + 8'd1 == TO) begin
                    granted_d = 1'b0;
                    done_d    = 1'b1;
                    fail_d    = (fail_q >= MF) ? MF : fail_q + 2'd1;
                    state_d   = (fail_d == MF) ? LOCKOUT : IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            LOCKOUT: begin
                if (clear_lockout) begin
                    fail_d  = 2'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d == SEND) || (state_d == WAIT_RESP);
        lock_d  = (state_d == LOCKOUT);
        valid_d = (state_d == SEND);
        seq_d   = valid_d ? code_d[{idx_d, 2'b00} +: 4] : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= 16'd0;
            idx_q     <= 2'd0;
            timer_q   <= 8'd0;
            fail_q    <= 2'd0;
            granted_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            lock_q    <= 1'b0;
            valid_q   <= 1'b0;
            seq_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            fail_q    <= fail_d;
            granted_q <= granted_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            lock_q    <= lock_d;
            valid_q   <= valid_d;
            seq_q     <= seq_d;
        end
    end

    assign lk.in_seq    = seq_q;
    assign lk.seq_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign granted      = granted_q;
    assign fail_cnt     = fail_q;
    assign locked_out   = lock_q;
endmodule

// File: doc/lock_code_sender.md
LOCK_CODE_SENDER -- requirements
Module: lock_code_sender

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have parameter RESP_TIMEOUT, default 8, meaning cycles allowed for lock response after last digit (legal range 1-255).
REQ-003 SHALL have parameter MAX_FAILS, default 3, meaning consecutive failed attempts before lockout (legal range 1-3).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request one code-entry attempt; sampled only in IDLE.
REQ-007 code  input  16  four-digit code; digit0=code[3:0] sent first, digit3=code[15:12] sent last.
REQ-008 in_seq  output  4  current digit presented to the lock.
REQ-009 seq_valid  output  1  in_seq holds a valid digit.
REQ-010 seq_ready  input  1  lock accepts digit this cycle.
REQ-011 unlock  input  4  lock status; 4'b1111 = access granted, any other value = not granted.
REQ-012 clear_lockout  input  1  leave LOCKOUT state.
REQ-013 busy  output  1  attempt in progress (SEND or WAIT_RESP).
REQ-014 done  output  1  one-cycle pulse at end of each attempt.
REQ-015 granted  output  1  result of last completed attempt; valid from done until the next start.
REQ-016 fail_cnt  output  2  consecutive failed attempts.
REQ-017 locked_out  output  1  high while in LOCKOUT.

Function
REQ-018 SHALL implement states IDLE, SEND, WAIT_RESP, LOCKOUT.
REQ-019 IDLE with start=1: latch code into an internal register, digit index=0, timer=0, granted=0, next state SEND; code changes after this cycle SHALL NOT affect the attempt.
REQ-020 SEND: seq_valid=1, in_seq=latched digit[index]; in_seq and seq_valid SHALL hold stable until seq_valid&&seq_ready.
REQ-021 A transfer occurs on a cycle with seq_valid&&seq_ready; index increments by 1; at most one digit per cycle; back-to-back transfers allowed (4 digits in 4 cycles minimum).
REQ-022 Transfer of digit3 SHALL move to WAIT_RESP next cycle; seq_valid=0 and in_seq=4'b0000 outside SEND.
REQ-023 SEND has no timeout; seq_ready held low stalls indefinitely.
REQ-024 WAIT_RESP: timer increments each cycle; unlock sampled every cycle including the first.
REQ-025 unlock==4'b1111 in WAIT_RESP: granted=1, fail_cnt=0, done pulse, next IDLE.
REQ-026 Timer reaching RESP_TIMEOUT cycles without grant: granted=0, fail_cnt+1, done pulse, next IDLE, or LOCKOUT if new fail_cnt==MAX_FAILS.
REQ-027 Grant and timeout in the same cycle: grant wins.
REQ-028 fail_cnt SHALL saturate at MAX_FAILS and never wrap.
REQ-029 LOCKOUT: locked_out=1, start ignored, seq_valid=0; clear_lockout=1 -> fail_cnt=0, next IDLE.
REQ-030 done asserts exactly once per completed attempt, in the cycle the result is registered; total latency with ready always high and immediate grant: start at cycle 0, digits transfer cycles 1-4, grant sampled cycle 5, done high cycle 6.
REQ-031 start asserted while busy or in LOCKOUT SHALL be ignored; clear_lockout outside LOCKOUT SHALL be ignored.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 rst=1 at any clock edge, including mid-SEND or mid-WAIT_RESP: state=IDLE, in_seq=0, seq_valid=0, busy=0, done=0, granted=0, fail_cnt=0, locked_out=0, index=0, timer=0; rst has priority over all inputs.

Verification
REQ-034 code=16'h4321, seq_ready=1, unlock=4'hF after 4th digit -> in_seq 1,2,3,4 on consecutive cycles, done pulse, granted=1, fail_cnt=0.
REQ-035 seq_ready toggled 1,0,0,1,... -> in_seq/seq_valid stable across stalls, exactly 4 transfers in order, no digit skipped or repeated.
REQ-036 unlock held 4'h0, RESP_TIMEOUT=8 -> done exactly 8 cycles after entering WAIT_RESP, granted=0, fail_cnt=1.
REQ-037 three consecutive timeouts -> locked_out=1, fail_cnt=3, start ignored; clear_lockout pulse -> IDLE, fail_cnt=0, next start accepted.
REQ-038 rst asserted after 2nd digit transfer -> all outputs reset next cycle; a following start resends from digit0.
REQ-039 unlock=4'hF on final timeout cycle -> granted=1, fail_cnt=0 (grant wins).
